// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD counter / 7-segment display slice.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp is never lit.
package bcd_disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DIG_OFF   = 8'hFF;

  // Binary to packed BCD; only used on parameters, so it folds to a constant.
  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value, input int ndigits);
    logic [4*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < ndigits) r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter_display_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability debounce, and a
// one-cycle pulse on each debounced press (high-to-low) edge.
module key_debounce #(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_raw,
  output logic press,
  output logic level
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      level_d = sync2_q;
      press_d = level_q & ~sync2_q;
    end
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
  assign level = level_q;

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up-counter with modulus, key preload and pause, driving a
// multiplexed common-anode 7-segment display. Single clock, enable-based.
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYC    = 1000000,
  parameter int NUM_DIGITS = 2,
  parameter int COUNT_MAX  = 20,
  parameter int PRELOAD    = 8,
  parameter int LZ_BLANK   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key,
  input  logic                    pause,
  output logic [7:0]              dig,
  output logic [7:0]              seg,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [4*MAX_DIGITS-1:0] MAX_FULL = to_bcd(COUNT_MAX, NUM_DIGITS);
  localparam logic [4*MAX_DIGITS-1:0] PRE_FULL = to_bcd(PRELOAD, NUM_DIGITS);
  localparam logic [CW-1:0]           MAX_BCD  = MAX_FULL[CW-1:0];
  localparam logic [CW-1:0]           PRE_BCD  = PRE_FULL[CW-1:0];

  // ---------------- enable generators ----------------
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          tick_en, scan_en;

  always_comb begin
    tick_en    = (tick_cnt_q == TW'(TICK_DIV - 1));
    scan_en    = (scan_cnt_q == SW'(SCAN_DIV - 1));
    tick_cnt_d = tick_en ? '0 : tick_cnt_q + TW'(1);
    scan_cnt_d = scan_en ? '0 : scan_cnt_q + SW'(1);
  end

  // ---------------- key path ----------------
  logic press, key_level;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key (
    .clk       (clk),
    .rst       (rst),
    .key_n_raw (key),
    .press     (press),
    .level     (key_level)
  );

  // ---------------- counter ----------------
  logic [CW-1:0] count_q, count_d, count_inc;
  logic          wrap_q, wrap_d;

  always_comb begin : bcd_increment
    logic carry;
    carry     = 1'b1;
    count_inc = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Press outranks the tick and ignores pause.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (press) begin
      count_d = PRE_BCD;
    end else if (tick_en && !pause) begin
      if (count_q == MAX_BCD) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_inc;
      end
    end
  end

  // ---------------- display scan ----------------
  logic [IW-1:0]         idx_q, idx_d;
  logic                  scan_on_q;
  logic [7:0]            dig_q, dig_d, seg_q, seg_d;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            cur_digit;
  logic                  cur_blank;

  always_comb begin
    idx_d = idx_q;
    if (scan_en) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // A digit above the units is blank when it and every higher digit is zero.
  always_comb begin : lz_detect
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_above;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_digit = count_q[4*i +: 4];
        cur_blank = lz_mask[i];
      end
    end
  end

  // Display stays dark until the first scan step after reset.
  always_comb begin
    dig_d = dig_q;
    seg_d = seg_q;
    if (scan_en) dig_d = ~(8'd1 << idx_d);
    if (scan_en || scan_on_q) begin
      seg_d = ((LZ_BLANK != 0) && cur_blank) ? SEG_BLANK : seg_decode(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      idx_q      <= '0;
      scan_on_q  <= 1'b0;
      dig_q      <= DIG_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      idx_q      <= idx_d;
      scan_on_q  <= scan_on_q | scan_en;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign dig       = dig_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display: counting, wrap, BCD carry, key
// debounce/preload, pause, scan and leading-zero blanking, mid-run reset.
module tb_bcd_counter_display;

  logic       clk = 1'b0;
  logic       rst, key, pause;
  logic [7:0] dig, seg, count_bcd;
  logic       wrap;
  logic [7:0] dig_lz, seg_lz, count_lz;
  logic       wrap_lz;

  int asserts   = 0;
  int failures  = 0;
  int edge_n    = 0;
  int wrap_seen = 0;

  always #5 clk = ~clk;

  bcd_counter_display #(
    .TICK_DIV(10), .SCAN_DIV(4), .DEB_CYC(3), .NUM_DIGITS(2),
    .COUNT_MAX(20), .PRELOAD(8), .LZ_BLANK(0)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .pause(pause),
    .dig(dig), .seg(seg), .count_bcd(count_bcd), .wrap(wrap)
  );

  bcd_counter_display #(
    .TICK_DIV(10), .SCAN_DIV(4), .DEB_CYC(3), .NUM_DIGITS(2),
    .COUNT_MAX(20), .PRELOAD(8), .LZ_BLANK(1)
  ) dut_lz (
    .clk(clk), .rst(rst), .key(key), .pause(pause),
    .dig(dig_lz), .seg(seg_lz), .count_bcd(count_lz), .wrap(wrap_lz)
  );

  // Edges since reset release; a tick lands on every edge where this is a multiple of 10.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_seen = wrap_seen + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_seg(input logic [7:0] v, input logic [7:0] d, input bit lz);
    logic [3:0] n;
    n = (d == 8'hFE) ? v[3:0] : v[7:4];
    if (lz && d == 8'hFD && v[7:4] == 4'd0) return 8'hFF;
    case (n)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hC0;
    endcase
  endfunction

  // Advance to the negedge just after the next tick edge.
  task automatic to_tick_edge();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((edge_n % 10 != 0) && n < 12);
    check("tick_budget", 8'(edge_n % 10), 8'd0);
  endtask

  task automatic tick_expect(input string tag, input int v);
    to_tick_edge();
    check(tag, count_bcd, bcd8(v));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] vb;
    logic [7:0] dsmp [1:9];
    int         v;
    int         dev;

    rst = 1'b1; key = 1'b1; pause = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", count_bcd, 8'h00);
    check("rst_dig",   dig,       8'hFF);
    check("rst_seg",   seg,       8'hFF);
    check("rst_wrap",  8'(wrap),  8'd0);
    rst = 1'b0;

    // Free run 00..20 then wrap, with scan/segment sampling at selected counts.
    for (int s = 1; s <= 21; s++) begin
      v  = s - 1;
      vb = bcd8(v);
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        if (j <= 9) begin
          dsmp[j] = dig;
          if (v == 0 && j <= 3) check("dig_pre_scan", dig, 8'hFF);
          if (v == 0 && j == 4) check("dig_first_scan", dig, 8'hFD);
          if ((v == 0 || v == 5 || v == 10 || v == 20) && dig != 8'hFF) begin
            check("dig_upper_off", {2'b00, dig[7:2]}, 8'h3F);
            check($sformatf("seg_at_%0d", v), seg, exp_seg(vb, dig, 1'b0));
            check($sformatf("seg_lz_at_%0d", v), seg_lz, exp_seg(vb, dig_lz, 1'b1));
          end
        end else begin
          check($sformatf("count_step_%0d", s), count_bcd, (s == 21) ? 8'h00 : bcd8(s));
          check($sformatf("wrap_step_%0d", s), 8'(wrap), (s == 21) ? 8'd1 : 8'd0);
          if (s == 10) check("bcd_carry_09_10", count_bcd, 8'h10);
        end
      end
      if (v == 20) begin
        check("dig_scan_valid", 8'(dsmp[1] == 8'hFE || dsmp[1] == 8'hFD), 8'd1);
        check("dig_alt_4cyc",   8'(dsmp[1] != dsmp[5]), 8'd1);
        check("dig_period_8",   dsmp[9], dsmp[1]);
      end
    end
    @(negedge clk);
    check("wrap_one_cycle", 8'(wrap), 8'd0);

    // Bounce of 2 cycles must not load.
    key = 1'b0;
    repeat (2) @(negedge clk);
    key = 1'b1;
    tick_expect("bounce_rejected", 1);

    // Real press while running: load, hold gives nothing more, release gives nothing.
    key = 1'b0;
    repeat (9) @(negedge clk);
    check("press_load", count_bcd, 8'h08);
    tick_expect("held_no_reload_a", 9);
    tick_expect("held_no_reload_b", 10);
    key = 1'b1;
    tick_expect("release_no_load_a", 11);
    tick_expect("release_no_load_b", 12);
    tick_expect("run_13", 13);
    tick_expect("run_14", 14);
    tick_expect("run_15", 15);

    // Press pulse lands on the same edge as the tick at count 15.
    repeat (3) @(negedge clk);
    key = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_coincide_15", count_bcd, 8'h15);
    to_tick_edge();
    check("press_beats_tick", count_bcd, 8'h08);
    key = 1'b1;
    tick_expect("after_coincide", 9);

    // Pause freezes the count through several ticks; a press still loads.
    pause = 1'b1;
    dev   = 0;
    repeat (50) begin
      @(negedge clk);
      if (count_bcd !== 8'h09) dev++;
    end
    check("pause_deviations", 8'(dev), 8'd0);
    check("pause_frozen", count_bcd, 8'h09);
    key = 1'b0;
    repeat (10) @(negedge clk);
    check("press_in_pause", count_bcd, 8'h08);
    key = 1'b1;
    repeat (10) @(negedge clk);
    check("pause_after_release", count_bcd, 8'h08);
    pause = 1'b0;
    tick_expect("resume_09", 9);
    tick_expect("resume_10", 10);
    tick_expect("resume_11", 11);
    tick_expect("resume_12", 12);
    tick_expect("resume_13", 13);

    // Reset in the middle of a debounce at count 13.
    key = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    key = 1'b1;
    @(negedge clk);
    check("midrst_count",  count_bcd, 8'h00);
    check("midrst_dig",    dig,       8'hFF);
    check("midrst_seg",    seg,       8'hFF);
    check("midrst_seg_lz", seg_lz,    8'hFF);
    check("midrst_wrap",   8'(wrap),  8'd0);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    check("no_phantom_press", count_bcd, 8'h00);
    @(negedge clk);
    check("first_tick_after_rst", count_bcd, 8'h01);
    check("wrap_total", 8'(wrap_seen), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Parametrised successor of the single-key two-digit counter.
- Runs an N-digit BCD up-counter with a programmable modulus, preloaded by a debounced key, plus a pause mode.
- Drives a multiplexed common-anode 7-segment display with optional leading-zero blanking.
- Fully single-clock: dividers produce one-cycle enables, not derived clocks. Sits between board I/O (key, display) and any logic consuming the count.

Parameters:
- TICK_DIV, 50000000, clk cycles per count tick (1 Hz at 50 MHz).
- SCAN_DIV, 50000, clk cycles per display scan step (1 kHz).
- DEB_CYC, 1000000, clk cycles the synchronised key must be stable to register (20 ms).
- NUM_DIGITS, 2, displayed BCD digits, legal 1..8.
- COUNT_MAX, 20, last value before wrap to 0; must be < 10^NUM_DIGITS.
- PRELOAD, 8, value loaded on key press; must be <= COUNT_MAX.
- LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key  in  1  raw push-button, active-low (pressed = 0), asynchronous to clk.
- pause  in  1  level; 1 holds the count, ticks are ignored.
- dig  out  8  digit enables, active-low; bit i selects digit i (0 = units).
- seg  out  8  segments {dp,g..a}, active-low.
- count_bcd  out  4*NUM_DIGITS  current count, BCD, digit 0 in bits [3:0].
- wrap  out  1  one-cycle pulse when the count wraps COUNT_MAX -> 0.

Behaviour:
- Reset (rst=1 at a clk edge) sets count_bcd=0, wrap=0, dig=8'hFF, seg=8'hFF, scan index=0, divider counters=0, debounce state=released. It takes effect the same edge, overrides every other event, and discards any press in progress.
- Tick generators: free-running counters 0..DIV-1. The enable pulses for exactly one cycle when the counter equals DIV-1, then the counter returns to 0. The first tick_en occurs TICK_DIV cycles after reset release. Divider counter width is $clog2(DIV).
- Key path:
  - 2-FF synchroniser on key.
  - Debounce counter resets on any change of the synchronised level.
  - When the synchronised level has been stable for DEB_CYC consecutive cycles, that level becomes the debounced state.
  - A debounced 1->0 transition produces a one-cycle press pulse.
  - Holding the key produces no further pulses; release produces none.
- Count update, priority high to low:
  - rst.
  - press: count_bcd <= PRELOAD. Applies even when pause=1 and even when it coincides with tick_en.
  - tick_en with pause=0:
    - If count_bcd == COUNT_MAX, count_bcd <= 0 and wrap=1 for that cycle.
    - Otherwise BCD increment, rippling the carry digit to digit (9 -> 0, next digit +1).
  - otherwise hold.
- PRELOAD and COUNT_MAX are converted to BCD constants at elaboration. Comparison is on the BCD vector.
- count_bcd and wrap are registered: visible the cycle after the qualifying edge.
- Scan:
  - On scan_en, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - dig and seg are registered together from the new idx: dig = ~(1<<idx); bits >= NUM_DIGITS are always 1.
  - Between scan_en pulses dig is held constant. seg may follow count changes on any cycle (same registered stage).
- Segment decode, digit value -> seg:
  - 0 c0, 1 f9, 2 a4, 3 b0, 4 99, 5 92, 6 82, 7 f8, 8 80, 9 90.
  - Non-BCD -> c0. dp is always 1 (off).
- Leading-zero blanking: with LZ_BLANK=1, a digit i>0 whose value and all higher digits' values are 0 outputs seg=8'hFF. Its dig bit still scans.
- Until the first scan_en after reset, dig=8'hFF.

Decomposition:
- Shared package bcd_disp_pkg:
  - SEG_* constants for 0-9 and SEG_BLANK=8'hFF, DIG_OFF=8'hFF.
  - Function to_bcd(int, ndigits) for elaboration-time conversion.
  - Function seg_decode(4-bit) -> 8-bit.
- One sub-module key_debounce (params DEB_CYC): ports clk, rst, key_n_raw -> press pulse, level. Reusable by other board blocks.

Test Plan:
Bench parameters: TICK_DIV=10, SCAN_DIV=4, DEB_CYC=3, NUM_DIGITS=2, COUNT_MAX=20, PRELOAD=8.
- Reset then free run, pause=0 -> count_bcd steps 00,01..20 every 10 cycles; the next tick gives 00 with wrap=1 for exactly one cycle; wrap never pulses otherwise.
- Count reaches 09, then tick -> count_bcd=8'h10 (BCD carry; never 0A).
- key low for 2 cycles then high -> no load (bounce rejected). key low for 6 cycles -> count_bcd=8'h08 once, no further load while held, none on release.
- Press pulse on the same cycle as tick_en at count 15 -> result 08, not 16. pause=1 for 50 cycles -> count frozen; a press during pause still loads 08.
- Scan at count 20: dig alternates FE/FD every 4 cycles; seg is a4 when dig=FE? no — seg is c0 when dig=FE and a4 when dig=FD; dig[7:2] always 1. LZ_BLANK=1 at count 05 -> seg=FF when dig=FD, 92 when dig=FE.
- Assert rst mid-count (count 13) and mid-debounce -> next cycle count_bcd=0, dig=FF, seg=FF, wrap=0; no phantom press after release.
